// File: rtl/fpga_spi_pkg.sv
// Shared types and defaults for the Arduino <-> FPGA SPI link.
package fpga_spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_t;

  localparam int unsigned SPI_DATA_W  = 8;
  localparam logic [7:0]  SPI_TX_IDLE = 8'h00;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer that brings one asynchronous SPI pin into FPGA_clk.
// RST_VAL sets the idle level the chain holds during reset.
module spi_input_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic FPGA_clk,
  input  logic FPGA_reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) sr <= {STAGES{RST_VAL}};
    else            sr <= {sr[STAGES-2:0], din};
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/fpga_spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first), FPGA end of the Arduino link.
// Oversamples sclk/mosi/ss_n in FPGA_clk; sclk must be <= FPGA_clk/8.
// Optional macro FPGA_SPI_ECHO_EN: with no tx byte pending, the shifter loads
// the most recently received byte instead of TX_IDLE.
module fpga_spi_slave
  import fpga_spi_pkg::*;
#(
  parameter int unsigned       DATA_W   = SPI_DATA_W,
  parameter int unsigned       SYNC_STG = 2,
  parameter logic [DATA_W-1:0] TX_IDLE  = DATA_W'(SPI_TX_IDLE)
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_reset,
  input  logic              arduino_sclk,
  input  logic              arduino_mosi,
  input  logic              arduino_ss_n,
  output logic              fpga_physical_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_abort
);

  localparam int unsigned      CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  spi_state_t state, state_next;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-2:0] tx_shift;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] load_val;

  logic do_load, do_sample, do_finish, do_shift, do_end;

  spi_input_sync #(.STAGES(SYNC_STG), .RST_VAL(1'b0)) u_sclk_sync (
    .FPGA_clk(FPGA_clk), .FPGA_reset(FPGA_reset), .din(arduino_sclk), .dout(sclk_s)
  );
  spi_input_sync #(.STAGES(SYNC_STG), .RST_VAL(1'b0)) u_mosi_sync (
    .FPGA_clk(FPGA_clk), .FPGA_reset(FPGA_reset), .din(arduino_mosi), .dout(mosi_s)
  );
  spi_input_sync #(.STAGES(SYNC_STG), .RST_VAL(1'b1)) u_ss_sync (
    .FPGA_clk(FPGA_clk), .FPGA_reset(FPGA_reset), .din(arduino_ss_n), .dout(ss_s)
  );

  // Edge-detect delay flops for the synchronized sclk and ss_n.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign rx_next  = {rx_shift, mosi_s};
  assign tx_ready = ~hold_full;
  assign busy     = (state == SPI_SHIFT);

  // State register.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) state <= SPI_IDLE;
    else            state <= state_next;
  end

  // Next state and one-hot datapath actions; ss_n rise outranks any sclk edge.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_finish  = 1'b0;
    do_shift   = 1'b0;
    do_end     = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (ss_fall) begin
          state_next = SPI_SHIFT;
          do_load    = 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (ss_rise) begin
          state_next = SPI_IDLE;
          do_end     = 1'b1;
        end else if (sclk_rise) begin
          if (bit_cnt == LAST) do_finish = 1'b1;
          else                 do_sample = 1'b1;
        end else if (sclk_fall && bit_cnt != '0) begin
          do_shift = 1'b1;
        end
      end
      default: state_next = SPI_IDLE;
    endcase
  end

`ifdef FPGA_SPI_ECHO_EN
  // Byte for the next frame; echo uses the byte completing this very cycle.
  always_comb load_val = hold_full ? hold : (do_finish ? rx_next : rx_data);
`else
  // Byte for the next frame: pending tx byte or the idle filler.
  always_comb load_val = hold_full ? hold : TX_IDLE;
`endif

  // Shift registers, bit counter, tx holding register and output pulses.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      bit_cnt            <= '0;
      rx_shift           <= '0;
      tx_shift           <= '0;
      hold               <= '0;
      hold_full          <= 1'b0;
      rx_data            <= '0;
      rx_valid           <= 1'b0;
      frame_abort        <= 1'b0;
      fpga_physical_miso <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;

      // A consume only happens when full and a write only when empty, so a
      // write offered during a consume from empty lands after the TX_IDLE load.
      if ((do_load || do_finish) && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (do_load) begin
        bit_cnt            <= '0;
        tx_shift           <= load_val[DATA_W-2:0];
        fpga_physical_miso <= load_val[DATA_W-1];
      end

      if (do_sample) begin
        rx_shift <= rx_next[DATA_W-2:0];
        bit_cnt  <= bit_cnt + 1'b1;
      end

      if (do_finish) begin
        rx_data            <= rx_next;
        rx_valid           <= 1'b1;
        bit_cnt            <= '0;
        tx_shift           <= load_val[DATA_W-2:0];
        fpga_physical_miso <= load_val[DATA_W-1];
      end

      if (do_shift) begin
        fpga_physical_miso <= tx_shift[DATA_W-2];
        tx_shift           <= tx_shift << 1;
      end

      if (do_end) begin
        frame_abort        <= (bit_cnt != '0);
        bit_cnt            <= '0;
        fpga_physical_miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpga_spi_slave.sv
// Self-checking bench for fpga_spi_slave: SPI master model at FPGA_clk/10,
// rx frames checked through an expected-byte queue by a separate monitor.
module tb_fpga_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, ss_n, miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_abort;

  int passed = 0;
  int total  = 0;
  int rx_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] exp_rx_q[$];

  always #5 clk = ~clk;

  fpga_spi_slave #(.DATA_W(8), .SYNC_STG(2), .TX_IDLE(8'h00)) dut (
    .FPGA_clk(clk), .FPGA_reset(rst),
    .arduino_sclk(sclk), .arduino_mosi(mosi), .arduino_ss_n(ss_n),
    .fpga_physical_miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_abort(frame_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every rx_valid pulse is matched against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) begin
          check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
        end
      end
      if (frame_abort) abort_cnt++;
    end
  end

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #50;
    ss_n = 1'b1;
    #100;
  endtask

  // Master: drive mosi while sclk low, sample miso at the rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #50;
      rd   = {rd[6:0], miso};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_a, rd_b;
    int rx_base, ab_base;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    tx_data = '0; tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_miso",     32'(miso), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_data",  32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_abort",    32'(frame_abort), 0);
    rst = 1'b0;
    #100;

    // Single frame with preloaded A5.
    push_tx(8'hA5);
    check("hold_full_ready", 32'(tx_ready), 0);
    exp_rx_q.push_back(8'h3C);
    rx_base = rx_cnt;
    ss_low();
    check("busy_in_frame", 32'(busy), 1);
    check("ready_after_load", 32'(tx_ready), 1);
    xfer(8'h3C, 8, rd_a);
    ss_high();
    check("miso_a5", 32'(rd_a), 32'hA5);
    check("rx_once", 32'(rx_cnt - rx_base), 1);
    check("rx_data_3c", 32'(rx_data), 32'h3C);
    check("busy_after", 32'(busy), 0);
    check("miso_idle", 32'(miso), 0);

    // Back-to-back frames, only 11 queued.
    push_tx(8'h11);
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'hC3);
    ss_low();
    xfer(8'h5A, 8, rd_a);
    xfer(8'hC3, 8, rd_b);
    ss_high();
    check("miso_11", 32'(rd_a), 32'h11);
    check("miso_idle_byte", 32'(rd_b), 32'h00);
    check("rx_data_c3", 32'(rx_data), 32'hC3);

    // Abort after 5 bits.
    rx_base = rx_cnt;
    ab_base = abort_cnt;
    ss_low();
    xfer(8'hFF, 5, rd_a);
    ss_high();
    check("abort_pulse", 32'(abort_cnt - ab_base), 1);
    check("abort_no_rx", 32'(rx_cnt - rx_base), 0);
    check("abort_rx_kept", 32'(rx_data), 32'hC3);
    exp_rx_q.push_back(8'h96);
    ss_low();
    xfer(8'h96, 8, rd_a);
    ss_high();
    check("post_abort_miso", 32'(rd_a), 32'h00);
    check("post_abort_rx", 32'(rx_data), 32'h96);

    // Reset in the middle of a frame with a byte pending.
    push_tx(8'h99);
    ab_base = abort_cnt;
    ss_low();
    xfer(8'hAA, 4, rd_a);
    rst = 1'b1;
    ss_n = 1'b1;
    #30;
    check("mid_rst_miso",  32'(miso), 0);
    check("mid_rst_ready", 32'(tx_ready), 1);
    check("mid_rst_rx",    32'(rx_data), 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_abort", 32'(frame_abort), 0);
    rst = 1'b0;
    #100;
    exp_rx_q.push_back(8'hE7);
    ss_low();
    xfer(8'hE7, 8, rd_a);
    ss_high();
    check("post_rst_miso", 32'(rd_a), 32'h00);
    check("post_rst_rx", 32'(rx_data), 32'hE7);
    check("post_rst_no_abort", 32'(abort_cnt - ab_base), 0);

    // sclk activity while deselected.
    rx_base = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
    #100;
    check("idle_sclk_no_rx", 32'(rx_cnt - rx_base), 0);
    check("idle_sclk_miso", 32'(miso), 0);
    check("idle_sclk_busy", 32'(busy), 0);

    // Nothing queued: 77 then 00; second read shows echo or idle byte.
    exp_rx_q.push_back(8'h77);
    exp_rx_q.push_back(8'h00);
    ss_low();
    xfer(8'h77, 8, rd_a);
    ss_high();
    ss_low();
    xfer(8'h00, 8, rd_b);
    ss_high();
`ifdef FPGA_SPI_ECHO_EN
    check("echo_read", 32'(rd_b), 32'h77);
`else
    check("no_echo_read", 32'(rd_b), 32'h00);
`endif

    #100;
    check("rx_queue_empty", 32'(exp_rx_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
